// File: rtl/rggen_external_apb_bridge_if.sv
// rggen_bus_if
//   Register-bus handshake between a register block (master) and an
//   external bus bridge (slave).
//   request      : master holds high until done
//   address      : byte address of the access
//   direction    : 1 = write, 0 = read (see rggen_rtl_pkg::rggen_direction)
//   write_data   : write payload
//   write_strobe : byte enables for write_data
//   done         : one-cycle completion pulse from the slave
//   read_data    : read payload, valid while done is high
//   status       : response code, valid while done is high
interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    logic                   request;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                   direction;
    logic [BUS_WIDTH-1:0]   write_data;
    logic [BUS_WIDTH/8-1:0] write_strobe;
    logic                   done;
    logic [BUS_WIDTH-1:0]   read_data;
    logic [1:0]             status;

    modport master (
        output request, address, direction, write_data, write_strobe,
        input  done, read_data, status
    );

    modport slave (
        input  request, address, direction, write_data, write_strobe,
        output done, read_data, status
    );
endinterface

// File: rtl/rggen_external_apb_bridge.sv
// rggen_rtl_pkg
//   Shared encodings for the register bus direction and response status.
//
// rggen_external_apb_bridge
//   Converts one rggen_bus_if access at a time into an APB transfer.
//   Ports:
//     clk, rst      : clock (rising edge) and synchronous active-high reset
//     bus_if        : rggen_bus_if slave side (request in, done/response out)
//     psel, penable : APB phase controls
//     paddr, pwrite : APB address and direction (held from SETUP through ACCESS)
//     pwdata, pstrb : APB write payload and byte strobes (zero on reads)
//     pready        : APB ready from the completer
//     prdata        : APB read data
//     pslverr       : APB error response
//   Every output is a register or a decode of registers only.
package rggen_rtl_pkg;
    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_direction;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;
endpackage

module rggen_external_apb_bridge
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
)(
    input  logic                      clk,
    input  logic                      rst,
    rggen_bus_if.slave                bus_if,
    output logic                      psel,
    output logic                      penable,
    output logic [ADDRESS_WIDTH-1:0]  paddr,
    output logic                      pwrite,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic                      pready,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pslverr
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RESPOND = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   strb_q, strb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    slverr_q, slverr_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    logic capture_req;
    logic access_done;
    logic timeout_hit;

    // In ACCESS psel and penable are both high, so pready alone qualifies
    // the completion sample.
    assign capture_req = (state_q == ST_IDLE) && bus_if.request;
    assign access_done = (state_q == ST_ACCESS) && pready;
    // pready has priority: the timeout only fires on a cycle without it.
    assign timeout_hit = TIMEOUT_EN && (state_q == ST_ACCESS) && !pready
                         && (cnt_q == CNT_LAST);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            rdata_q  <= rdata_d;
            slverr_q <= slverr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus_if.request) state_d = ST_SETUP;
            ST_SETUP:   state_d = ST_ACCESS;
            ST_ACCESS:  if (pready || timeout_hit) state_d = ST_RESPOND;
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Request capture, response capture and timeout counter
    always_comb begin
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        rdata_d  = rdata_q;
        slverr_d = slverr_q;
        cnt_d    = cnt_q;

        if (capture_req) begin
            addr_d  = bus_if.address;
            write_d = (bus_if.direction == RGGEN_WRITE);
            // Reads present zero data and strobes on the APB side.
            wdata_d = (bus_if.direction == RGGEN_WRITE) ? bus_if.write_data : '0;
            strb_d  = (bus_if.direction == RGGEN_WRITE) ? bus_if.write_strobe : '0;
        end

        // Clearing in SETUP means the counter starts from zero on the first
        // ACCESS cycle.
        if (state_q == ST_SETUP) begin
            cnt_d = '0;
        end else if ((state_q == ST_ACCESS) && !pready && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        if (access_done) begin
            rdata_d  = write_q ? '0 : prdata;
            slverr_d = pslverr;
        end else if (timeout_hit) begin
            rdata_d  = '0;
            slverr_d = 1'b1;
        end
    end

    // Output decode
    always_comb begin
        psel             = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
        penable          = (state_q == ST_ACCESS);
        paddr            = addr_q;
        pwrite           = write_q;
        pwdata           = wdata_q;
        pstrb            = strb_q;
        bus_if.done      = (state_q == ST_RESPOND);
        bus_if.read_data = (state_q == ST_RESPOND) ? rdata_q : '0;
        bus_if.status    = ((state_q == ST_RESPOND) && slverr_q) ? RGGEN_SLAVE_ERROR
                                                                 : RGGEN_OKAY;
    end
endmodule
